// File: rtl/dp_ram_pipe.sv
// Simple dual-port RAM with per-byte write enables, a 1- or 2-stage read
// pipeline, a defined read-during-write result and asynchronous pipeline reset.
module dp_ram_pipe #(
   parameter int DATA_W    = 64,
   parameter int ADDR_W    = 12,
   parameter int DEPTH     = 2**ADDR_W,
   parameter int RD_LAT    = 1,
   parameter int BYPASS    = 1,
   parameter int ZERO_IDLE = 1
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                wr,
   input  logic [ADDR_W-1:0]   wr_add,
   input  logic [DATA_W/8-1:0] wr_be,
   input  logic [DATA_W-1:0]   in,
   input  logic                rd,
   input  logic [ADDR_W-1:0]   rd_add,
   output logic [DATA_W-1:0]   out,
   output logic                out_vld,
   output logic                collision
);

   localparam int NB = DATA_W / 8;
   localparam logic [ADDR_W:0] DEPTH_L = DEPTH[ADDR_W:0];

   logic [DATA_W-1:0] mem_q [DEPTH];

   logic              wr_ok, rd_ok, col_d;
   logic [DATA_W-1:0] rdat_d;

   logic              s1_vld_q, s1_col_q;
   logic [DATA_W-1:0] s1_dat_q;
   logic              o_vld, o_col;
   logic [DATA_W-1:0] o_dat;

   assign wr_ok = wr && ({1'b0, wr_add} < DEPTH_L);
   assign rd_ok = {1'b0, rd_add} < DEPTH_L;

   // Collision data is the old word, optionally overlaid with the enabled new bytes
   always_comb begin
      rdat_d = '0;
      col_d  = rd && wr && rd_ok && (rd_add == wr_add);
      if (rd_ok) rdat_d = mem_q[rd_add];
      if (col_d && BYPASS != 0) begin
         for (int i = 0; i < NB; i++) begin
            if (wr_be[i]) rdat_d[8*i +: 8] = in[8*i +: 8];
         end
      end
   end

   // The array itself is never cleared; rst only gates writes and flushes reads
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         s1_vld_q <= 1'b0;
         s1_col_q <= 1'b0;
         s1_dat_q <= '0;
      end else begin
         s1_vld_q <= rd;
         s1_col_q <= col_d;
         if (rd) s1_dat_q <= rdat_d;
         if (wr_ok) begin
            for (int i = 0; i < NB; i++) begin
               if (wr_be[i]) mem_q[wr_add][8*i +: 8] <= in[8*i +: 8];
            end
         end
      end
   end

   generate
      if (RD_LAT == 2) begin : g_lat2
         logic              s2_vld_q, s2_col_q;
         logic [DATA_W-1:0] s2_dat_q;

         always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
               s2_vld_q <= 1'b0;
               s2_col_q <= 1'b0;
               s2_dat_q <= '0;
            end else begin
               s2_vld_q <= s1_vld_q;
               s2_col_q <= s1_col_q;
               if (s1_vld_q) s2_dat_q <= s1_dat_q;
            end
         end

         assign o_vld = s2_vld_q;
         assign o_col = s2_col_q;
         assign o_dat = s2_dat_q;
      end else begin : g_lat1
         assign o_vld = s1_vld_q;
         assign o_col = s1_col_q;
         assign o_dat = s1_dat_q;
      end
   endgenerate

   assign out_vld   = o_vld;
   assign collision = o_col;
   assign out       = (ZERO_IDLE != 0 && !o_vld) ? '0 : o_dat;

endmodule

// File: tb/tb_dp_ram_pipe.sv
// Bench for dp_ram_pipe: a default instance and a RD_LAT=2/BYPASS=0/DEPTH=3000
// instance share stimulus; directed table, corner sequences and random traffic.
module tb_dp_ram_pipe;

   logic        clk = 1'b0;
   logic        rst;
   logic        wr, rd;
   logic [11:0] wa, ra;
   logic [7:0]  be;
   logic [63:0] din;
   logic [63:0] o0, o1;
   logic        v0, v1, c0, c1;

   int checks = 0;
   int errors = 0;
   int cyc = 0;

   always #5 clk = ~clk;

   dp_ram_pipe u0 (
      .clk(clk), .rst(rst), .wr(wr), .wr_add(wa), .wr_be(be), .in(din),
      .rd(rd), .rd_add(ra), .out(o0), .out_vld(v0), .collision(c0)
   );

   dp_ram_pipe #(.DEPTH(3000), .RD_LAT(2), .BYPASS(0), .ZERO_IDLE(0)) u1 (
      .clk(clk), .rst(rst), .wr(wr), .wr_add(wa), .wr_be(be), .in(din),
      .rd(rd), .rd_add(ra), .out(o1), .out_vld(v1), .collision(c1)
   );

   typedef struct {
      int          due;
      logic [63:0] d;
      logic        c;
   } pend_t;

   pend_t       pq [2][$];
   logic [63:0] mm [int];
   logic [63:0] last [2];

   function automatic logic [63:0] merge(logic [63:0] o, logic [63:0] n,
                                         logic [7:0] b);
      for (int i = 0; i < 8; i++) if (b[i]) o[8*i +: 8] = n[8*i +: 8];
      return o;
   endfunction

   function automatic logic [63:0] initv(logic [11:0] a);
      return {20'hC0FFE, a, 20'h12345, ~a};
   endfunction

   task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s (cycle %0d): got %h, expected %h", name, cyc, act, exp);
      end
   endtask

   // Reference: each read is resolved at acceptance against the pre-write memory
   task automatic model_edge();
      if (rst) begin
         for (int k = 0; k < 2; k++) begin
            pq[k].delete();
            last[k] = '0;
         end
         return;
      end
      for (int k = 0; k < 2; k++) begin
         int    dep = (k == 0) ? 4096 : 3000;
         int    lat = (k == 0) ? 1 : 2;
         bit    bp  = (k == 0);
         int    rk  = k * 8192 + int'(ra);
         int    wk  = k * 8192 + int'(wa);
         pend_t p;
         if (rd) begin
            p.due = cyc + lat - 1;
            if (int'(ra) < dep) begin
               p.c = wr && (wa == ra);
               p.d = mm.exists(rk) ? mm[rk] : 64'h0;
               if (p.c && bp) p.d = merge(p.d, din, be);
            end else begin
               p.c = 1'b0;
               p.d = '0;
            end
            pq[k].push_back(p);
         end
         if (wr && int'(wa) < dep) begin
            mm[wk] = merge(mm.exists(wk) ? mm[wk] : 64'h0, din, be);
         end
      end
   endtask

   task automatic model_check();
      for (int k = 0; k < 2; k++) begin
         logic        ev, ec;
         logic [63:0] ed;
         ev = 1'b0;
         ec = 1'b0;
         ed = (k == 0) ? 64'h0 : last[k];
         if (pq[k].size() > 0 && pq[k][0].due == cyc) begin
            pend_t p;
            p = pq[k].pop_front();
            ev = 1'b1;
            ec = p.c;
            ed = p.d;
            last[k] = p.d;
         end
         if (k == 0) begin
            chk("m0_vld", {63'h0, v0}, {63'h0, ev});
            chk("m0_out", o0, ed);
            chk("m0_col", {63'h0, c0}, {63'h0, ec});
         end else begin
            chk("m1_vld", {63'h0, v1}, {63'h0, ev});
            chk("m1_out", o1, ed);
            chk("m1_col", {63'h0, c1}, {63'h0, ec});
         end
      end
   endtask

   task automatic step();
      @(posedge clk);
      cyc++;
      model_edge();
      #1;
      model_check();
   endtask

   task automatic idle();
      wr = 1'b0;
      rd = 1'b0;
   endtask

   typedef struct {
      logic        wr;
      logic [11:0] wa;
      logic [7:0]  be;
      logic [63:0] din;
      logic        rd;
      logic [11:0] ra;
      logic        v0;
      logic [63:0] o0;
      logic        c0;
      logic        v1;
      logic [63:0] o1;
      logic        c1;
   } vec_t;

   vec_t tbl [12];

   logic [11:0] pool [20];

   initial begin
      logic [63:0] A, F, K, M;
      A = 64'hAAAA_AAAA_AAAA_AAAA;
      F = 64'hFFFF_FFFF_FFFF_FFFF;
      K = 64'h1122_3344_5566_7788;
      M = 64'h5555_5555_AAAA_AAAA;
      tbl[0]  = '{1, 12'h000, 8'hFF, K, 0, 12'h000, 0, 0, 0, 0, 0, 0};
      tbl[1]  = '{0, 12'h000, 8'h00, 0, 1, 12'h000, 1, K, 0, 0, 0, 0};
      tbl[2]  = '{0, 12'h000, 8'h00, 0, 0, 12'h000, 0, 0, 0, 1, K, 0};
      tbl[3]  = '{1, 12'hFFF, 8'hFF, F, 0, 12'h000, 0, 0, 0, 0, K, 0};
      tbl[4]  = '{1, 12'hFFF, 8'h0F, 0, 0, 12'h000, 0, 0, 0, 0, K, 0};
      tbl[5]  = '{0, 12'h000, 8'h00, 0, 1, 12'hFFF, 1, 64'hFFFF_FFFF_0000_0000, 0,
                  0, K, 0};
      tbl[6]  = '{1, 12'h010, 8'hFF, A, 0, 12'h000, 0, 0, 0, 1, 0, 0};
      tbl[7]  = '{1, 12'h010, 8'hF0, 64'h5555_5555_5555_5555, 1, 12'h010,
                  1, M, 1, 0, 0, 0};
      tbl[8]  = '{0, 12'h000, 8'h00, 0, 1, 12'h010, 1, M, 0, 1, A, 1};
      tbl[9]  = '{1, 12'h000, 8'h00, 0, 1, 12'h000, 1, K, 1, 1, M, 0};
      tbl[10] = '{0, 12'h000, 8'h00, 0, 0, 12'h000, 0, 0, 0, 1, K, 1};
      tbl[11] = '{0, 12'h000, 8'h00, 0, 0, 12'h000, 0, 0, 0, 0, K, 0};

      for (int i = 0; i < 16; i++) pool[i] = 12'(i);
      pool[16] = 12'd500;
      pool[17] = 12'd3500;
      pool[18] = 12'hFFF;
      pool[19] = 12'h010;

      // Reset state
      rst = 1'b1;
      idle();
      wa = '0; ra = '0; be = '0; din = '0;
      #1;
      chk("rst_v0", {63'h0, v0}, 64'h0);
      chk("rst_o0", o0, 64'h0);
      chk("rst_v1", {63'h0, v1}, 64'h0);
      chk("rst_o1", o1, 64'h0);
      repeat (2) step();
      rst = 1'b0;

      // Known contents for every address the bench reads
      for (int i = 0; i < 20; i++) begin
         wr = 1'b1; wa = pool[i]; be = 8'hFF; din = initv(pool[i]);
         step();
      end
      idle();

      // Directed table
      for (int i = 0; i < 12; i++) begin
         wr = tbl[i].wr; wa = tbl[i].wa; be = tbl[i].be; din = tbl[i].din;
         rd = tbl[i].rd; ra = tbl[i].ra;
         step();
         chk($sformatf("t%0d_v0", i), {63'h0, v0}, {63'h0, tbl[i].v0});
         chk($sformatf("t%0d_o0", i), o0, tbl[i].o0);
         chk($sformatf("t%0d_c0", i), {63'h0, c0}, {63'h0, tbl[i].c0});
         chk($sformatf("t%0d_v1", i), {63'h0, v1}, {63'h0, tbl[i].v1});
         chk($sformatf("t%0d_o1", i), o1, tbl[i].o1);
         chk($sformatf("t%0d_c1", i), {63'h0, c1}, {63'h0, tbl[i].c1});
      end
      idle();

      // Back-to-back reads through the two-stage pipe
      begin
         logic        ev [5];
         logic [11:0] ea [5];
         ev = '{0, 1, 1, 1, 0};
         ea = '{0, 1, 2, 3, 0};
         for (int i = 0; i < 5; i++) begin
            rd = (i < 3);
            ra = 12'(i + 1);
            step();
            chk($sformatf("b2b%0d_v1", i), {63'h0, v1}, {63'h0, ev[i]});
            if (ev[i]) chk($sformatf("b2b%0d_o1", i), o1, initv(ea[i]));
         end
      end
      idle();

      // Reset between acceptance and presentation
      rd = 1'b1; ra = 12'd2;
      step();
      idle();
      rst = 1'b1;
      #1;
      chk("mid_rst_v0", {63'h0, v0}, 64'h0);
      chk("mid_rst_v1", {63'h0, v1}, 64'h0);
      chk("mid_rst_o1", o1, 64'h0);
      step();
      rst = 1'b0;
      step();
      rd = 1'b1; ra = 12'd2;
      step();
      idle();
      step();
      chk("post_rst_v1", {63'h0, v1}, 64'h1);
      chk("post_rst_o1", o1, initv(12'd2));

      // Out-of-range access on the DEPTH=3000 instance
      wr = 1'b1; wa = 12'd3500; be = 8'hFF; din = 64'hDEAD_BEEF_0BAD_F00D;
      step();
      wr = 1'b0; rd = 1'b1; ra = 12'd3500;
      step();
      idle();
      step();
      chk("oor_v1", {63'h0, v1}, 64'h1);
      chk("oor_o1", o1, 64'h0);
      chk("oor_c1", {63'h0, c1}, 64'h0);
      rd = 1'b1; ra = 12'd500;
      step();
      idle();
      step();
      chk("nowrap_o1", o1, initv(12'd500));

      // Random traffic against the reference model
      for (int n = 0; n < 400; n++) begin
         rst = ($urandom_range(0, 49) == 0);
         wr  = 1'($urandom);
         rd  = 1'($urandom);
         be  = 8'($urandom);
         din = {$urandom, $urandom};
         wa  = pool[$urandom_range(0, 19)];
         ra  = ($urandom_range(0, 3) == 0) ? wa : pool[$urandom_range(0, 19)];
         step();
      end
      rst = 1'b0;
      idle();
      repeat (3) step();

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
